wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter B_DEPTH, default 2, meaning the depth of the port-B pending-write buffer (legal 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports a_valid (in, 1), a_rd (in, 5) and a_data (in, 32), carrying the in-order pipeline writeback result.
REQ-005 SHALL have port a_ready, output, 1, tied to 1 (the pipeline writeback is never back-pressured).
REQ-006 SHALL have ports b_valid (in, 1), b_rd (in, 5), b_data (in, 32) and b_ready (out, 1), carrying the long-latency unit result under a valid/ready handshake.
REQ-007 SHALL have ports w_enable (out, 1), w_addr (out, 5) and w_data (out, 32), all registered, forming the register-file write port.
REQ-008 SHALL have port busy_mask, output, 32; bit n is set while a live buffered port-B write to xn is pending.
REQ-009 SHALL have ports q_addr (in, 5), q_hit (out, 1) and q_data (out, 32), the forwarding query.

Function
REQ-010 SHALL accept port A whenever a_valid=1, and accept port B on any cycle with b_valid=1 and b_ready=1.
REQ-011 SHALL drive b_ready=1 combinationally when the buffer count is below B_DEPTH, and 0 when it is full.
REQ-012 SHALL issue at most one write per cycle. Priority: port A first, then the buffer head, then a direct port-B bypass.
REQ-013 SHALL register an accepted port-A write to w_* on the next edge (latency 1).
REQ-014 SHALL bypass an accepted port-B write directly to w_* (latency 1) when a_valid=0 and the buffer is empty; otherwise it SHALL push the write into the buffer tail.
REQ-015 SHALL pop the buffer head to w_* on any cycle with a_valid=0.
REQ-016 SHALL allow a push and a pop in the same cycle; the count is then unchanged.
REQ-017 SHALL wrap the buffer pointers modulo B_DEPTH and keep the count in the range 0..B_DEPTH.
REQ-018 SHALL complete the accept handshake for any write to x0 (rd=0) but never assert w_enable for it, buffer it, or set any busy_mask bit for it.
REQ-019 SHALL handle write-after-write ordering as follows. An accepted port-A write with rd=X SHALL mark every buffered entry with rd=X dead. A port-B write with rd=X accepted in the same cycle SHALL also be dropped.
REQ-020 SHALL still pop dead entries in order, but a dead entry SHALL produce w_enable=0 for its slot.
REQ-021 SHALL drive w_enable=0 on every cycle with no write issued, and SHALL hold w_addr/w_data at their previous values on those cycles.
REQ-022 SHALL compute busy_mask combinationally as the OR of one-hot(rd) over all live buffered entries.

Reset
REQ-023 SHALL, while rst_n=0, clear w_enable, w_addr, w_data, the pointers, the count and all live bits, regardless of clk.
REQ-024 SHALL present b_ready=1, busy_mask=0 and q_hit=0 immediately after reset release.
REQ-025 SHALL discard any buffered writes that are in flight when reset asserts; they SHALL never reach w_*.

Configuration
REQ-026 SHALL implement forwarding only when macro WB_ARBITER_FWD_EN is defined. In that case q_hit and q_data are combinational: q_hit=1 if q_addr!=0 and it matches either the registered w_* write (w_enable=1) or the youngest live buffered entry. On a match, q_data SHALL be the youngest matching value, with w_* taking precedence.
REQ-027 SHALL, when WB_ARBITER_FWD_EN is undefined, keep the q_* ports present but drive q_hit=0 and q_data=0, with no lookup logic.

Verification
REQ-028 Scenario 1: a_valid with a_rd=5, a_data=0x11 -> next cycle w_enable=1, w_addr=5, w_data=0x11.
REQ-029 Scenario 2: with the buffer empty and a_valid=0, b_valid with b_rd=7, b_data=0x22 -> next cycle w_enable=1, w_addr=7, w_data=0x22, busy_mask=0.
REQ-030 Scenario 3: hold a_valid=1 for 4 cycles while offering port-B writes to rd 1, 2, 3 (B_DEPTH=2) -> rd 1 and 2 accepted, b_ready=0 on the third offer, busy_mask=0x6.
REQ-031 Scenario 3 continued: drop a_valid -> rd1 then rd2 written in order, then rd3 accepted.
REQ-032 Scenario 4: buffer a port-B write to rd 9 = 0xAA, then issue port A to rd 9 = 0xBB -> w_data=0xBB is written and the rd-9 pop slot shows w_enable=0. busy_mask bit 9 clears on the port-A acceptance.
REQ-033 Scenario 5: a port-A and a port-B write, both with rd=0 -> both handshakes complete, w_enable stays 0, busy_mask=0.
REQ-034 Scenario 6: with WB_ARBITER_FWD_EN defined and rd 4 = 0x33 buffered, q_addr=4 gives q_hit=1, q_data=0x33. Assert rst_n=0 mid-buffer -> busy_mask=0 and q_hit=0 at once, and no rd-4 write is ever issued.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter (pipeline port A, buffered port B); forwarding under WB_ARBITER_FWD_EN
module wb_arbiter #(
    parameter int B_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        w_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] busy_mask,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
);

    localparam int PW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int CW = $clog2(B_DEPTH + 1);

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [B_DEPTH-1:0] live;
    logic [B_DEPTH-1:0] live_nxt;
    logic [4:0]         buf_rd   [B_DEPTH];
    logic [31:0]        buf_data [B_DEPTH];

    logic        b_accept;
    logic        buf_empty;
    logic        do_pop;
    logic        do_bypass;
    logic        b_drop;
    logic        do_push;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [31:0] issue_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(B_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign a_ready   = 1'b1;
    assign b_ready   = (count != CW'(B_DEPTH));
    assign b_accept  = b_valid && b_ready;
    assign buf_empty = (count == '0);
    assign do_pop    = !a_valid && !buf_empty;
    assign do_bypass = !a_valid && buf_empty && b_accept;
    // x0 writes and writes superseded by a same-cycle port-A write are swallowed
    assign b_drop    = (b_rd == 5'd0) || (a_valid && (a_rd == b_rd));
    assign do_push   = b_accept && !do_bypass && !b_drop;

    // Select the single write for this cycle: port A, else buffer head, else bypass
    always_comb begin
        issue_en   = 1'b0;
        issue_rd   = a_rd;
        issue_data = a_data;
        if (a_valid) begin
            issue_en = (a_rd != 5'd0);
        end else if (!buf_empty) begin
            issue_en   = live[head];
            issue_rd   = buf_rd[head];
            issue_data = buf_data[head];
        end else if (b_accept) begin
            issue_en   = (b_rd != 5'd0);
            issue_rd   = b_rd;
            issue_data = b_data;
        end
    end

    // Register-file write port; address/data hold when nothing is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_enable <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            w_enable <= issue_en;
            if (issue_en) begin
                w_addr <= issue_rd;
                w_data <= issue_data;
            end
        end
    end

    // Live bits: port A kills older buffered writes to the same rd, pop frees, push claims
    always_comb begin
        live_nxt = live;
        for (int i = 0; i < B_DEPTH; i++) begin
            if (a_valid && (buf_rd[i] == a_rd)) live_nxt[i] = 1'b0;
        end
        if (do_pop)  live_nxt[head] = 1'b0;
        if (do_push) live_nxt[tail] = 1'b1;
    end

    // Buffer pointers, occupancy and live bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            live  <= '0;
        end else begin
            if (do_pop)  head <= ptr_inc(head);
            if (do_push) tail <= ptr_inc(tail);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            live <= live_nxt;
        end
    end

    // Payload storage; validity is carried by the live bits alone
    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_rd[tail]   <= b_rd;
            buf_data[tail] <= b_data;
        end
    end

    // Scoreboard view of registers with a pending buffered write
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < B_DEPTH; i++) begin
            if (live[i]) busy_mask[buf_rd[i]] = 1'b1;
        end
    end

`ifdef WB_ARBITER_FWD_EN
    int fwd_slot;

    // Forwarding lookup: scan oldest to youngest so the youngest match wins, w_* overrides
    always_comb begin
        q_hit    = 1'b0;
        q_data   = '0;
        fwd_slot = 0;
        for (int i = 0; i < B_DEPTH; i++) begin
            fwd_slot = int'(head) + i;
            if (fwd_slot >= B_DEPTH) fwd_slot = fwd_slot - B_DEPTH;
            if (live[PW'(fwd_slot)] && (buf_rd[PW'(fwd_slot)] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = buf_data[PW'(fwd_slot)];
            end
        end
        if (w_enable && (w_addr == q_addr)) begin
            q_hit  = 1'b1;
            q_data = w_data;
        end
        if (q_addr == 5'd0) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end
`else
    logic unused_q_addr;

    // Forwarding disabled: query port is inert
    assign unused_q_addr = ^q_addr;
    assign q_hit         = 1'b0;
    assign q_data        = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;

    localparam int DEPTH = 2;
`ifdef WB_ARBITER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] busy_mask;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    always #5 clk = ~clk;

    wb_arbiter #(.B_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy_mask (busy_mask),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_data    (q_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_bacc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic logic [32:0] m_fwd(input logic [4:0] q);
        if (!FWD || q == 5'd0) return 33'd0;
        if (m_wen && m_waddr == q) return {1'b1, m_wdata};
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].live && mq[i].rd == q) return {1'b1, mq[i].data};
        return 33'd0;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registered outputs
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bdata,
                        input logic [4:0] qa);
        logic [32:0] f;
        bit          bypass;
        ent_t        e;
        ent_t        n;
        a_valid = av; a_rd = ard; a_data = adata;
        b_valid = bv; b_rd = brd; b_data = bdata;
        q_addr  = qa;
        #1;
        f = m_fwd(qa);
        chk("a_ready", 32'(a_ready), 32'd1);
        chk("b_ready", 32'(b_ready), 32'(mq.size() < DEPTH));
        chk("busy_mask", busy_mask, m_busy());
        chk("q_hit", 32'(q_hit), 32'(f[32]));
        chk("q_data", q_data, f[31:0]);
        m_bacc = bv && (mq.size() < DEPTH);
        bypass = 1'b0;
        m_wen  = 1'b0;
        if (av) begin
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
            if (ard != 5'd0) begin m_wen = 1'b1; m_waddr = ard; m_wdata = adata; end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin m_wen = 1'b1; m_waddr = e.rd; m_wdata = e.data; end
        end else if (m_bacc) begin
            bypass = 1'b1;
            if (brd != 5'd0) begin m_wen = 1'b1; m_waddr = brd; m_wdata = bdata; end
        end
        if (m_bacc && !bypass && brd != 5'd0 && !(av && ard == brd)) begin
            n.rd = brd; n.data = bdata; n.live = 1'b1;
            mq.push_back(n);
        end
        @(posedge clk);
        #1;
        chk("w_enable", 32'(w_enable), 32'(m_wen));
        chk("w_addr", 32'(w_addr), 32'(m_waddr));
        chk("w_data", w_data, m_wdata);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge
    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; q_addr = 5'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst w_enable", 32'(w_enable), 32'd0);
        chk("rst w_addr", 32'(w_addr), 32'd0);
        chk("rst w_data", w_data, 32'd0);
        chk("rst busy_mask", busy_mask, 32'd0);
        chk("rst q_hit", 32'(q_hit), 32'd0);
        chk("rst b_ready", 32'(b_ready), 32'd1);
        mq.delete();
        m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        @(posedge clk);
        #1;
        chk("rst held w_enable", 32'(w_enable), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] brd;
        rst_n = 1'b0;
        a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
        q_addr = 5'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Scenario 1: port A write, latency one
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("sc1 w_enable", 32'(w_enable), 32'd1);
        chk("sc1 w_addr", 32'(w_addr), 32'd5);
        chk("sc1 w_data", w_data, 32'h11);

        // Scenario 2: port B bypass with empty buffer
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 5'd0);
        chk("sc2 w_enable", 32'(w_enable), 32'd1);
        chk("sc2 w_addr", 32'(w_addr), 32'd7);
        chk("sc2 w_data", w_data, 32'h22);
        chk("sc2 busy_mask", busy_mask, 32'd0);
        idle();

        // Scenario 3: port A holds the write port while port B fills the buffer
        brd = 5'd1;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 5'd10, 32'(c), 1'b1, brd, 32'h100 + 32'(brd), 5'd0);
            if (m_bacc) brd = brd + 5'd1;
        end
        chk("sc3 next offer", 32'(brd), 32'd3);
        chk("sc3 b_ready full", 32'(b_ready), 32'd0);
        chk("sc3 busy_mask", busy_mask, 32'h6);
        step(1'b0, 5'd0, 32'd0, 1'b1, brd, 32'h103, 5'd0);
        chk("sc3 pop1 addr", 32'(w_addr), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, brd, 32'h103, 5'd0);
        chk("sc3 pop2 addr", 32'(w_addr), 32'd2);
        chk("sc3 rd3 accepted", 32'(m_bacc), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("sc3 pop3 addr", 32'(w_addr), 32'd3);
        chk("sc3 pop3 data", w_data, 32'h103);

        // Scenario 4: port A supersedes a buffered write to the same register
        step(1'b1, 5'd10, 32'h1, 1'b1, 5'd9, 32'hAA, 5'd0);
        chk("sc4 busy bit9", busy_mask, 32'h200);
        step(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("sc4 w_data", w_data, 32'hBB);
        chk("sc4 busy cleared", busy_mask, 32'd0);
        idle();
        chk("sc4 dead slot", 32'(w_enable), 32'd0);
        chk("sc4 data held", w_data, 32'hBB);

        // Scenario 5: writes to x0 complete the handshake but never write
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0);
        chk("sc5 w_enable", 32'(w_enable), 32'd0);
        chk("sc5 busy_mask", busy_mask, 32'd0);
        idle();

        // Scenario 6: buffered rd4 visible to the query, then discarded by reset
        step(1'b1, 5'd12, 32'h5, 1'b1, 5'd4, 32'h33, 5'd4);
        step(1'b1, 5'd12, 32'h6, 1'b0, 5'd0, 32'd0, 5'd4);
        chk("sc6 busy bit4", busy_mask, 32'h10);
        do_reset();
        for (int c = 0; c < 3; c++) idle();

        // Randomized traffic on a small register range to force collisions
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        for (int c = 0; c < 4; c++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
